// File: rtl/oled_ctrl_vram.sv
// SSD1306-class display controller core: command/parameter decoder, paged VRAM
// with horizontal/vertical/page addressing, and a 1-cycle pixel read port.
`timescale 1ns/1ps
module oled_ctrl_vram #(
  parameter int COLS            = 128,
  parameter int PAGES           = 8,
  parameter int COL_W           = $clog2(COLS),
  parameter int PAGE_W          = (PAGES > 1) ? $clog2(PAGES) : 1,
  parameter int ROW_W           = $clog2(PAGES * 8),
  parameter bit PAGEADDR_COMPAT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_i,
  input  logic             dc_i,
  input  logic             rd_en_i,
  input  logic [COL_W:0]   rd_x_i,
  input  logic [ROW_W:0]   rd_y_i,
  output logic             rd_valid_o,
  output logic             rd_pix_o,
  output logic             on_o,
  output logic [7:0]       contrast_o,
  output logic             cmd_busy_o
);
  localparam int DEPTH = (1 << PAGE_W) * COLS;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [1:0] M_HORZ = 2'b00;
  localparam logic [1:0] M_VERT = 2'b01;

  typedef enum logic {S_IDLE, S_PARAM} state_e;

  function automatic logic [COL_W-1:0] to_col(input logic [7:0] v);
    return v[COL_W-1:0];
  endfunction

  function automatic logic [PAGE_W-1:0] to_page(input logic [7:0] v);
    return v[PAGE_W-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] to_row(input logic [7:0] v);
    return v[ROW_W-1:0];
  endfunction

  // Number of parameter bytes that follow an opcode; 0 for single-byte commands.
  function automatic logic [2:0] param_count(input logic [7:0] op);
    case (op)
      8'h20, 8'h81, 8'hA8, 8'hD3, 8'hD5,
      8'hD9, 8'hDA, 8'hDB, 8'h8D:         param_count = 3'd1;
      8'h21, 8'hA3:                       param_count = 3'd2;
      8'h22:                              param_count = PAGEADDR_COMPAT ? 3'd0 : 3'd2;
      8'h26, 8'h27:                       param_count = 3'd6;
      8'h29, 8'h2A:                       param_count = 3'd5;
      default:                            param_count = 3'd0;
    endcase
  endfunction

  logic              in_vld_q;
  logic [7:0]        in_byte_q;
  logic              in_dc_q;

  state_e            state_q, state_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [2:0]        pcnt_q, pcnt_d;
  logic [7:0]        p0_q, p0_d;
  logic [1:0]        mode_q, mode_d;
  logic [COL_W-1:0]  col_start_q, col_start_d, col_end_q, col_end_d, col_ptr_q, col_ptr_d;
  logic [PAGE_W-1:0] page_start_q, page_start_d, page_end_q, page_end_d, page_ptr_q, page_ptr_d;
  logic [7:0]        contrast_q, contrast_d;
  logic              on_q, on_d, invert_q, invert_d, all_on_q, all_on_d;
  logic              seg_remap_q, seg_remap_d, com_dec_q, com_dec_d;
  logic [ROW_W-1:0]  start_line_q, start_line_d;
  logic [2:0]        page_cnt_q, page_cnt_d;
  logic              wr_en;
  logic [7:0]        col8;

  // Input capture: each strobed byte is acted on in the following cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) in_vld_q <= 1'b0;
    else          in_vld_q <= byte_valid_i;
  end

  always_ff @(posedge clk_i) begin
    in_byte_q <= byte_i;
    in_dc_q   <= dc_i;
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    pcnt_d       = pcnt_q;
    p0_d         = p0_q;
    mode_d       = mode_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    col_ptr_d    = col_ptr_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    page_ptr_d   = page_ptr_q;
    contrast_d   = contrast_q;
    on_d         = on_q;
    invert_d     = invert_q;
    all_on_d     = all_on_q;
    seg_remap_d  = seg_remap_q;
    com_dec_d    = com_dec_q;
    start_line_d = start_line_q;
    page_cnt_d   = page_cnt_q;
    wr_en        = 1'b0;
    col8         = 8'(col_ptr_q);
    if (in_vld_q) begin
      if (in_dc_q) begin
        // A data byte always wins: any half-collected command is dropped.
        state_d = S_IDLE;
        pcnt_d  = 3'd0;
        wr_en   = 1'b1;
        case (mode_q)
          M_HORZ: begin
            if (col_ptr_q == col_end_q) begin
              col_ptr_d  = col_start_q;
              page_ptr_d = (page_ptr_q == page_end_q) ? page_start_q : page_ptr_q + 1'b1;
            end else begin
              col_ptr_d = col_ptr_q + 1'b1;
            end
          end
          M_VERT: begin
            if (page_ptr_q == page_end_q) begin
              page_ptr_d = page_start_q;
              col_ptr_d  = (col_ptr_q == col_end_q) ? col_start_q : col_ptr_q + 1'b1;
            end else begin
              page_ptr_d = page_ptr_q + 1'b1;
            end
          end
          default: col_ptr_d = (col_ptr_q == COL_MAX) ? col_start_q : col_ptr_q + 1'b1;
        endcase
      end else if (state_q == S_PARAM) begin
        if (pcnt_q == 3'd1) begin
          state_d = S_IDLE;
          pcnt_d  = 3'd0;
          case (opcode_q)
            8'h20: if (in_byte_q[1:0] != 2'b11) mode_d = in_byte_q[1:0];
            8'h21: begin
              col_start_d = to_col(p0_q);
              col_end_d   = to_col(in_byte_q);
              col_ptr_d   = to_col(p0_q);
            end
            8'h22: begin
              page_start_d = to_page(p0_q);
              page_end_d   = to_page(in_byte_q);
              page_ptr_d   = to_page(p0_q);
            end
            8'h81:   contrast_d = in_byte_q;
            default: ;
          endcase
        end else begin
          // Only two-parameter commands use the earlier byte, so one slot suffices.
          pcnt_d = pcnt_q - 3'd1;
          p0_d   = in_byte_q;
        end
      end else begin
        pcnt_d = param_count(in_byte_q);
        if (pcnt_d != 3'd0) begin
          state_d  = S_PARAM;
          opcode_d = in_byte_q;
        end else if (in_byte_q[7:5] == 3'b000) begin
          if (in_byte_q[4]) col8[7:4] = in_byte_q[3:0];
          else              col8[3:0] = in_byte_q[3:0];
          col_ptr_d = to_col(col8);
        end else if (in_byte_q[7:6] == 2'b01) begin
          start_line_d = to_row({2'b00, in_byte_q[5:0]});
        end else if (in_byte_q[7:3] == 5'b10110) begin
          page_ptr_d = to_page({5'b00000, in_byte_q[2:0]});
        end else begin
          case (in_byte_q)
            8'hA0, 8'hA1: seg_remap_d = in_byte_q[0];
            8'hC0, 8'hC8: com_dec_d   = in_byte_q[3];
            8'hA4, 8'hA5: all_on_d    = in_byte_q[0];
            8'hA6, 8'hA7: invert_d    = in_byte_q[0];
            8'hAE, 8'hAF: on_d        = in_byte_q[0];
            8'h22: begin
              // Legacy page addressing steps through pages 0..5 on each opcode.
              page_ptr_d = to_page({5'b00000, page_cnt_q});
              col_ptr_d  = '0;
              page_cnt_d = (page_cnt_q == 3'd5) ? 3'd0 : page_cnt_q + 3'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      opcode_q     <= 8'h00;
      pcnt_q       <= 3'd0;
      p0_q         <= 8'h00;
      mode_q       <= 2'b10;
      col_start_q  <= '0;
      col_end_q    <= COL_MAX;
      col_ptr_q    <= '0;
      page_start_q <= '0;
      page_end_q   <= PAGE_W'(PAGES - 1);
      page_ptr_q   <= '0;
      contrast_q   <= 8'h7F;
      on_q         <= 1'b1;
      invert_q     <= 1'b0;
      all_on_q     <= 1'b0;
      seg_remap_q  <= 1'b0;
      com_dec_q    <= 1'b0;
      start_line_q <= '0;
      page_cnt_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      pcnt_q       <= pcnt_d;
      p0_q         <= p0_d;
      mode_q       <= mode_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      col_ptr_q    <= col_ptr_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      page_ptr_q   <= page_ptr_d;
      contrast_q   <= contrast_d;
      on_q         <= on_d;
      invert_q     <= invert_d;
      all_on_q     <= all_on_d;
      seg_remap_q  <= seg_remap_d;
      com_dec_q    <= com_dec_d;
      start_line_q <= start_line_d;
      page_cnt_q   <= page_cnt_d;
    end
  end

  // Read address: mirror column/row, then rotate by start line.
  logic [COL_W-1:0]  rd_col;
  logic [ROW_W-1:0]  rd_r, rd_row;
  logic [PAGE_W-1:0] rd_page;
  logic              rd_oob;

  always_comb begin
    rd_col  = seg_remap_q ? ~rd_x_i[COL_W-1:0] : rd_x_i[COL_W-1:0];
    rd_r    = com_dec_q ? ~rd_y_i[ROW_W-1:0] : rd_y_i[ROW_W-1:0];
    rd_row  = rd_r + start_line_q;
    rd_page = to_page(8'(rd_row >> 3));
    rd_oob  = rd_x_i[COL_W] | rd_y_i[ROW_W];
  end

  logic [7:0] vram [DEPTH];
  logic [7:0] rd_byte_q;
  logic       rd_vld_q, rd_oob_q, rd_on_q, rd_all_on_q, rd_inv_q;
  logic [2:0] rd_bit_q;

  // Synchronous-read RAM; a write and read of the same byte returns the old value.
  always_ff @(posedge clk_i) begin
    if (wr_en) vram[{page_ptr_q, col_ptr_q}] <= in_byte_q;
    if (rd_en_i) begin
      rd_byte_q   <= vram[{rd_page, rd_col}];
      rd_bit_q    <= rd_row[2:0];
      rd_oob_q    <= rd_oob;
      rd_on_q     <= on_q;
      rd_all_on_q <= all_on_q;
      rd_inv_q    <= invert_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rd_vld_q <= 1'b0;
    else          rd_vld_q <= rd_en_i;
  end

  assign rd_valid_o = rd_vld_q;
  assign rd_pix_o   = rd_vld_q & ~rd_oob_q & rd_on_q &
                      (rd_all_on_q | (rd_inv_q ^ rd_byte_q[rd_bit_q]));
  assign on_o       = on_q;
  assign contrast_o = contrast_q;
  assign cmd_busy_o = (state_q == S_PARAM);

endmodule

// File: tb/tb_oled_ctrl_vram.sv
// Randomised bench for oled_ctrl_vram with a byte-level behavioural model of
// the command decoder, VRAM and pixel read path.
`timescale 1ns/1ps
module tb_oled_ctrl_vram;
  localparam int COLS  = 128;
  localparam int PAGES = 8;
  localparam int ROWS  = PAGES * 8;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic clk = 1'b0, rst_n = 1'b0;
  logic byte_valid = 1'b0, dc = 1'b0, rd_en = 1'b0;
  logic [7:0] byte_d = 8'h00;
  logic [COL_W:0] rd_x = '0;
  logic [ROW_W:0] rd_y = '0;
  logic rd_valid, rd_pix, on, busy;
  logic [7:0] contrast;

  always #5 clk = ~clk;

  oled_ctrl_vram #(.COLS(COLS), .PAGES(PAGES)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .byte_valid_i(byte_valid), .byte_i(byte_d),
    .dc_i(dc), .rd_en_i(rd_en), .rd_x_i(rd_x), .rd_y_i(rd_y),
    .rd_valid_o(rd_valid), .rd_pix_o(rd_pix), .on_o(on),
    .contrast_o(contrast), .cmd_busy_o(busy));

  int n_chk = 0, n_pass = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_on, m_contrast, m_inv, m_allon, m_seg, m_com, m_start, m_mode;
  int m_cs, m_ce, m_ps, m_pe, m_col, m_page, m_need, m_op;
  int m_params[$];
  logic [7:0] mvram [PAGES][COLS];
  logic pend_v = 1'b0, pend_dc = 1'b0;
  logic [7:0] pend_b = 8'h00;
  logic exp_vld = 1'b0, exp_pix = 1'b0;

  task automatic m_reset();
    m_on = 1; m_contrast = 8'h7F; m_inv = 0; m_allon = 0; m_seg = 0; m_com = 0;
    m_start = 0; m_mode = 2; m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
    m_col = 0; m_page = 0; m_need = 0; m_op = 0;
    m_params.delete();
  endtask

  function automatic int nparams(input int b);
    case (b)
      'h20, 'h81, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB, 'h8D: return 1;
      'h21, 'h22, 'hA3: return 2;
      'h26, 'h27: return 6;
      'h29, 'h2A: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic m_write(input logic [7:0] b);
    mvram[m_page][m_col] = b;
    if (m_mode == 0) begin
      if (m_col == m_ce) begin
        m_col = m_cs;
        m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
      end else m_col = (m_col + 1) % COLS;
    end else if (m_mode == 1) begin
      if (m_page == m_pe) begin
        m_page = m_ps;
        m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % COLS;
      end else m_page = (m_page + 1) % PAGES;
    end else begin
      m_col = (m_col == COLS - 1) ? m_cs : m_col + 1;
    end
  endtask

  task automatic m_single(input int b);
    if (b < 16)                  m_col = (m_col / 16) * 16 + b;
    else if (b < 32)             m_col = ((b % 16) * 16 + m_col % 16) % COLS;
    else if (b >= 64 && b < 128) m_start = (b - 64) % ROWS;
    else if (b >= 'hB0 && b <= 'hB7) m_page = (b - 'hB0) % PAGES;
    else case (b)
      'hA0: m_seg = 0;    'hA1: m_seg = 1;
      'hC0: m_com = 0;    'hC8: m_com = 1;
      'hA4: m_allon = 0;  'hA5: m_allon = 1;
      'hA6: m_inv = 0;    'hA7: m_inv = 1;
      'hAE: m_on = 0;     'hAF: m_on = 1;
      default: ;
    endcase
  endtask

  task automatic m_run();
    case (m_op)
      'h20: if ((m_params[0] & 3) != 3) m_mode = m_params[0] & 3;
      'h21: begin m_cs = m_params[0] % COLS; m_ce = m_params[1] % COLS; m_col = m_cs; end
      'h22: begin m_ps = m_params[0] % PAGES; m_pe = m_params[1] % PAGES; m_page = m_ps; end
      'h81: m_contrast = m_params[0];
      default: ;
    endcase
  endtask

  task automatic m_byte(input logic d, input logic [7:0] b);
    int n;
    if (d) begin
      m_need = 0; m_params.delete(); m_write(b);
    end else if (m_need > 0) begin
      m_params.push_back(int'(b));
      if (m_params.size() == m_need) begin m_run(); m_need = 0; m_params.delete(); end
    end else begin
      n = nparams(int'(b));
      if (n > 0) begin m_op = int'(b); m_need = n; m_params.delete(); end
      else m_single(int'(b));
    end
  endtask

  function automatic logic m_pixel(input int x, input int y);
    int pc, r, row;
    logic bitv;
    if (x >= COLS || y >= ROWS) return 1'b0;
    pc = m_seg ? COLS - 1 - x : x;
    r = m_com ? ROWS - 1 - y : y;
    row = (r + m_start) % ROWS;
    bitv = mvram[row / 8][pc][row % 8];
    return (m_on != 0) && ((m_allon != 0) || ((m_inv != 0) != bitv));
  endfunction

  // Model steps on the same edge as the DUT: read sees pre-update state.
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_reset(); pend_v = 1'b0; exp_vld = 1'b0; exp_pix = 1'b0;
    end else begin
      exp_vld = rd_en;
      if (rd_en) exp_pix = m_pixel(int'(rd_x), int'(rd_y));
      if (pend_v) m_byte(pend_dc, pend_b);
      pend_v = byte_valid; pend_dc = dc; pend_b = byte_d;
    end
  end

  always begin
    @(negedge clk);
    if (rst_n && checking) begin
      chk("rd_valid", rd_valid, exp_vld);
      if (exp_vld) chk("rd_pix", rd_pix, exp_pix);
      chk("on", on, m_on);
      chk("contrast", contrast, m_contrast);
      chk("busy", busy, m_need > 0);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] tbl [0:19] = '{8'h20, 8'h21, 8'h22, 8'h81, 8'hA0, 8'hA1, 8'hC0, 8'hC8,
                             8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hAF, 8'hAF, 8'hB2, 8'h0A,
                             8'h15, 8'h47, 8'hA3, 8'h26};

  task automatic send(input logic d, input logic [7:0] b);
    byte_valid = 1'b1; dc = d; byte_d = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] b); send(1'b0, b); endtask
  task automatic idle(input int n); repeat (n) @(negedge clk); endtask

  task automatic rd(input int x, input int y);
    rd_en = 1'b1; rd_x = x[COL_W:0]; rd_y = y[ROW_W:0];
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic chk_pix(input string name, input int x, input int y, input logic exp);
    rd(x, y);
    chk(name, rd_pix, exp);
  endtask

  task automatic chk_byte(input string name, input int pg, input int col, input logic [7:0] exp);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      rd(col, pg * 8 + i);
      v[i] = rd_pix;
    end
    chk(name, v, exp);
    chk({name, " model"}, mvram[pg][col], exp);
  endtask

  initial begin
    idle(3);
    chk("reset on", on, 1);
    chk("reset contrast", contrast, 8'h7F);
    chk("reset busy", busy, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_pix", rd_pix, 0);
    rst_n = 1'b1;
    checking = 1'b1;
    idle(2);

    // Fill all of VRAM so every later read has a defined expectation.
    cmd(8'h20); cmd(8'h00);
    for (int i = 0; i < PAGES * COLS; i++) send(1'b1, 8'($urandom));
    idle(2);

    // Windowed horizontal addressing.
    cmd(8'h21); idle(1); chk("busy after 0x21", busy, 1);
    cmd(8'h10); idle(1); chk("busy mid param", busy, 1);
    cmd(8'h13); idle(1); chk("busy after last param", busy, 0);
    cmd(8'h22); cmd(8'h01); cmd(8'h02); cmd(8'h20); cmd(8'h00);
    for (int i = 1; i <= 9; i++) send(1'b1, 8'(i));
    idle(2);
    chk_byte("horz p1c10", 1, 'h10, 8'h09);
    chk_byte("horz p1c11", 1, 'h11, 8'h02);
    chk_byte("horz p1c13", 1, 'h13, 8'h04);
    chk_byte("horz p2c10", 2, 'h10, 8'h05);
    chk_byte("horz p2c13", 2, 'h13, 8'h08);

    // Vertical addressing over the full panel.
    cmd(8'h21); cmd(8'h00); cmd(8'h7F); cmd(8'h22); cmd(8'h00); cmd(8'h07);
    cmd(8'h20); cmd(8'h01);
    for (int i = 0; i < 10; i++) send(1'b1, 8'hFF);
    send(1'b1, 8'h5A);
    idle(2);
    chk_byte("vert p7c0", 7, 0, 8'hFF);
    chk_byte("vert p1c1", 1, 1, 8'hFF);
    chk_byte("vert next ptr", 2, 1, 8'h5A);

    // Page addressing wrap at the last column.
    cmd(8'h20); cmd(8'h02); cmd(8'hB3); cmd(8'h0F); cmd(8'h17);
    send(1'b1, 8'hA1); send(1'b1, 8'hB2); send(1'b1, 8'hC3);
    idle(2);
    chk_byte("page p3c7f", 3, 'h7F, 8'hA1);
    chk_byte("page p3c0", 3, 0, 8'hB2);
    chk_byte("page p3c1", 3, 1, 8'hC3);

    // Pixel mapping: remap, COM direction, start line, invert, on/off, all-on.
    cmd(8'hB0); cmd(8'h05); cmd(8'h10); send(1'b1, 8'h80); idle(2);
    chk_pix("pix 5,7", 5, 7, 1);
    chk_pix("pix 5,6", 5, 6, 0);
    cmd(8'hA7); idle(1); chk_pix("inv 5,7", 5, 7, 0); cmd(8'hA6);
    cmd(8'hA1); idle(1); chk_pix("remap 122,7", 122, 7, 1);
    cmd(8'hA7); idle(1); chk_pix("remap inv", 122, 7, 0); cmd(8'hA6);
    cmd(8'hC8); idle(1); chk_pix("comdec 122,56", 122, 56, 1);
    cmd(8'hA7); idle(1); chk_pix("comdec inv", 122, 56, 0); cmd(8'hA6);
    cmd(8'hC0); cmd(8'hA0); cmd(8'h41); idle(1); chk_pix("start 5,6", 5, 6, 1);
    cmd(8'hA7); idle(1); chk_pix("start inv", 5, 6, 0); cmd(8'hA6);
    cmd(8'hAE); idle(1); chk_pix("display off", 5, 6, 0);
    cmd(8'hAF); cmd(8'hA5); idle(1);
    chk_pix("all_on", 5, 5, 1);
    chk_pix("oob x", COLS, 0, 0);
    chk("oob x valid", rd_valid, 1);
    chk_pix("oob y", 0, ROWS, 0);
    cmd(8'hA4); cmd(8'h40); idle(1);

    // Data byte aborts a pending contrast command.
    cmd(8'h81); send(1'b1, 8'hAA); idle(2);
    chk("contrast after abort", contrast, 8'h7F);
    chk("busy after abort", busy, 0);
    chk_byte("aborted data", 0, 6, 8'hAA);
    cmd(8'h81); cmd(8'h33); idle(1);
    chk("contrast set", contrast, 8'h33);

    // Random interleaving of bytes and reads.
    for (int i = 0; i < 2000; i++) begin
      byte_valid = ($urandom_range(0, 2) != 0);
      dc = ($urandom_range(0, 2) == 0);
      byte_d = ($urandom_range(0, 1) != 0) ? tbl[$urandom_range(0, 19)] : 8'($urandom);
      rd_en = $urandom_range(0, 1);
      rd_x = (COL_W + 1)'($urandom_range(0, COLS + 15));
      rd_y = (ROW_W + 1)'($urandom_range(0, ROWS + 7));
      @(negedge clk);
    end
    byte_valid = 1'b0; rd_en = 1'b0;
    idle(3);

    // Asynchronous reset in the middle of a parameter command.
    cmd(8'h21); idle(1); chk("busy before reset", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("busy in reset", busy, 0);
    chk("contrast in reset", contrast, 8'h7F);
    chk("on in reset", on, 1);
    chk("rd_valid in reset", rd_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd(8'h10); idle(1); chk("0x10 after reset", busy, 0);
    cmd(8'h13); send(1'b1, 8'h3C); idle(2);
    chk_byte("col high nibble", 0, 'h30, 8'h3C);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
